// File: rtl/nn_csr_pkg.sv
// Shared definitions for the NN inference CSR block: FSM states, CTRL/STATUS
// bit positions and the register-offset helpers that depend on N_CLASSES.
package nn_csr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } nn_state_e;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_CLR_BIT    = 2;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_ERR_BIT  = 2;

    localparam int RESULT_MAX_W = 16;

    // Probability snapshots occupy words 0..n-1; control words follow them.
    function automatic int ctrl_off(input int n);
        return n;
    endfunction

    function automatic int status_off(input int n);
        return n + 1;
    endfunction

    function automatic int result_off(input int n);
        return n + 2;
    endfunction

    function automatic int cycles_off(input int n);
        return n + 3;
    endfunction

    function automatic int map_words(input int n);
        return n + 4;
    endfunction

endpackage

// File: rtl/nn_argmax_seq.sv
// Sequential argmax over a packed vector of class probabilities: one class per
// cycle, lowest index wins ties; done/index/max are valid in the final cycle.
module nn_argmax_seq #(
    parameter int N_CLASSES = 10,
    parameter int PROB_W    = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic [N_CLASSES*PROB_W-1:0]   i_vec,
    output logic                          o_done,
    output logic [3:0]                    o_index,
    output logic [PROB_W-1:0]             o_max
);

    localparam int IDX_W = $clog2(N_CLASSES);

    logic                 r_busy;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     r_best_idx;
    logic [PROB_W-1:0]    r_best_val;

    logic [PROB_W-1:0]    w_cur;
    logic                 w_gt;
    logic                 w_last;
    logic [IDX_W-1:0]     w_next_idx;
    logic [PROB_W-1:0]    w_next_val;

    always_comb begin
        w_cur = '0;
        for (int i = 0; i < N_CLASSES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_cur = i_vec[i*PROB_W +: PROB_W];
            end
        end
    end

    // Strict compare keeps the earliest index on equal values; the zero seed
    // is harmless because index 0 is the first candidate either way.
    assign w_gt       = (w_cur > r_best_val);
    assign w_next_idx = w_gt ? r_idx : r_best_idx;
    assign w_next_val = w_gt ? w_cur : r_best_val;
    assign w_last     = (r_idx == IDX_W'(N_CLASSES - 1));

    assign o_done  = r_busy && w_last;
    assign o_index = 4'(w_next_idx);
    assign o_max   = w_next_val;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy     <= 1'b0;
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best_val <= '0;
        end else if (i_start) begin
            r_busy     <= 1'b1;
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best_val <= '0;
        end else if (r_busy) begin
            r_best_idx <= w_next_idx;
            r_best_val <= w_next_val;
            if (w_last) begin
                r_busy <= 1'b0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/avalon_nn_csr.sv
// Avalon-MM CSR front end for an NN core: starts an inference, snapshots the
// class probabilities, runs a sequential argmax and reports result and latency.
module avalon_nn_csr
    import nn_csr_pkg::*;
#(
    parameter int N_CLASSES = 10,
    parameter int PROB_W    = 16,
    parameter int ADDR_W    = 5
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          AVL_READ,
    input  logic                          AVL_WRITE,
    input  logic [ADDR_W-1:0]             AVL_ADDR,
    input  logic [31:0]                   AVL_WRITEDATA,
    output logic [31:0]                   AVL_READDATA,
    output logic                          IRQ,
    output logic                          NN_COMPUTE,
    input  logic                          NN_READY,
    input  logic [N_CLASSES*PROB_W-1:0]   NN_PROBABILITY,
    output logic [1:0]                    DBG_STATE
);

    if (N_CLASSES < 2 || N_CLASSES > 16) begin : g_bad_classes
        $error("avalon_nn_csr: N_CLASSES must be 2..16");
    end
    if (PROB_W < 1 || PROB_W > 32) begin : g_bad_prob_w
        $error("avalon_nn_csr: PROB_W must be 1..32");
    end
    if (map_words(N_CLASSES) > (2 ** ADDR_W)) begin : g_bad_addr_w
        $error("avalon_nn_csr: ADDR_W too small for the register map");
    end

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(ctrl_off(N_CLASSES));
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(status_off(N_CLASSES));
    localparam logic [ADDR_W-1:0] A_RESULT = ADDR_W'(result_off(N_CLASSES));
    localparam logic [ADDR_W-1:0] A_CYCLES = ADDR_W'(cycles_off(N_CLASSES));

    nn_state_e                     r_state;
    logic                          r_compute;
    logic                          r_irq_en;
    logic                          r_done;
    logic                          r_err;
    logic [N_CLASSES*PROB_W-1:0]   r_prob;
    logic [3:0]                    r_res_idx;
    logic [RESULT_MAX_W-1:0]       r_res_max;
    logic [31:0]                   r_cycles;
    logic [31:0]                   r_rdata;

    logic                          w_busy;
    logic                          w_ctrl_wr;
    logic                          w_start;
    logic                          w_clr;
    logic                          w_arg_start;
    logic                          w_arg_done;
    logic [3:0]                    w_arg_idx;
    logic [PROB_W-1:0]             w_arg_max;
    logic [31:0]                   w_rdata;
    logic                          w_unused_wdata;

    assign w_busy      = (r_state == ST_RUN) || (r_state == ST_SCAN);
    assign w_ctrl_wr   = AVL_WRITE && (AVL_ADDR == A_CTRL);
    assign w_start     = w_ctrl_wr && AVL_WRITEDATA[CTRL_START_BIT];
    assign w_clr       = w_ctrl_wr && AVL_WRITEDATA[CTRL_CLR_BIT];
    assign w_arg_start = (r_state == ST_RUN) && NN_READY;
    assign w_unused_wdata = ^AVL_WRITEDATA[31:3];

    nn_argmax_seq #(
        .N_CLASSES (N_CLASSES),
        .PROB_W    (PROB_W)
    ) u_argmax (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_start (w_arg_start),
        .i_vec   (r_prob),
        .o_done  (w_arg_done),
        .o_index (w_arg_idx),
        .o_max   (w_arg_max)
    );

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < N_CLASSES; i++) begin
            if (AVL_ADDR == ADDR_W'(i)) begin
                w_rdata = 32'(r_prob[i*PROB_W +: PROB_W]);
            end
        end
        if (AVL_ADDR == A_CTRL) begin
            w_rdata[CTRL_IRQ_EN_BIT] = r_irq_en;
        end
        if (AVL_ADDR == A_STATUS) begin
            w_rdata[STAT_BUSY_BIT] = w_busy;
            w_rdata[STAT_DONE_BIT] = r_done;
            w_rdata[STAT_ERR_BIT]  = r_err;
        end
        if (AVL_ADDR == A_RESULT) begin
            w_rdata = {r_res_max, 12'h000, r_res_idx};
        end
        if (AVL_ADDR == A_CYCLES) begin
            w_rdata = r_cycles;
        end
    end

    // Later assignments win: CLR is applied first, then a rejected START may
    // re-raise ERR and an accepted START clears DONE as it enters RUN.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_compute <= 1'b0;
            r_irq_en  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_prob    <= '0;
            r_res_idx <= '0;
            r_res_max <= '0;
            r_cycles  <= '0;
            r_rdata   <= '0;
        end else begin
            if (AVL_READ) begin
                r_rdata <= w_rdata;
            end
            if (w_ctrl_wr) begin
                r_irq_en <= AVL_WRITEDATA[CTRL_IRQ_EN_BIT];
            end
            if (w_clr) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            if (w_start && w_busy) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start) begin
                        r_state   <= ST_RUN;
                        r_compute <= 1'b1;
                        r_cycles  <= '0;
                        r_done    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (r_cycles != 32'hFFFF_FFFF) begin
                        r_cycles <= r_cycles + 32'd1;
                    end
                    if (NN_READY) begin
                        r_prob    <= NN_PROBABILITY;
                        r_compute <= 1'b0;
                        r_state   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_arg_done) begin
                        r_res_idx <= w_arg_idx;
                        r_res_max <= RESULT_MAX_W'(w_arg_max);
                        r_done    <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign AVL_READDATA = r_rdata;
    assign NN_COMPUTE   = r_compute;
    assign IRQ          = r_done && r_irq_en;
    assign DBG_STATE    = r_state;

endmodule
